// File: rtl/pmod_loop_tester.sv
// pmod_loop_tester: drives a chosen set of 8-bit patterns onto the pmod
// output bank, waits for the loopback cable to settle, then compares the
// synchronised return data against what was sent. It reports pass/fail,
// a mismatch count and the first pattern that came back wrong.

module pmod_loop_tester #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [7:0]  first_fail
);

    // The settle counter only ever holds SETTLE_CYCLES-1 down to 0.
    // SETTLE_CYCLES must be at least 3 so the two-flop synchronizer has
    // flushed the previous pattern before the compare.
    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] MODE_WALK1 = 2'd0;
    localparam logic [1:0] MODE_WALK0 = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    logic [2:0]       state;
    logic [1:0]       mode_q;
    logic [8:0]       idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [7:0]       rx_meta;
    logic [7:0]       rx_sync;
    logic [7:0]       pattern_cur;
    logic [8:0]       last_idx;
    logic             mismatch;
    logic [15:0]      err_next;

    // Two-flop synchronizer: the looped-back pins are asynchronous to clk,
    // so the comparator only ever looks at rx_sync.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 8'h00;
            rx_sync <= 8'h00;
        end else begin
            rx_meta <= rx_data;
            rx_sync <= rx_meta;
        end
    end

    // Pattern generator: the byte to drive for index idx in the latched mode.
    always_comb begin
        pattern_cur = 8'h00;
        case (mode_q)
            MODE_WALK1: pattern_cur = 8'h01 << idx[2:0];
            MODE_WALK0: pattern_cur = ~(8'h01 << idx[2:0]);
            MODE_COUNT: pattern_cur = idx[7:0];
            MODE_ALT:   pattern_cur = idx[0] ? 8'hAA : 8'h55;
            default:    pattern_cur = 8'h00;
        endcase
    end

    // Index of the final pattern of each set (pattern count minus one).
    always_comb begin
        last_idx = 9'd0;
        case (mode_q)
            MODE_WALK1: last_idx = 9'd7;
            MODE_WALK0: last_idx = 9'd7;
            MODE_COUNT: last_idx = 9'd255;
            MODE_ALT:   last_idx = 9'd1;
            default:    last_idx = 9'd0;
        endcase
    end

    // Compare result and the error count it would produce; pass is taken
    // from err_next so the final pattern's result is included.
    always_comb begin
        mismatch = (rx_sync != tx_data);
        err_next = mismatch ? (err_count + 16'd1) : err_count;
    end

    // done is asserted for exactly the single cycle spent in DONE.
    assign done = (state == ST_DONE);

    // Main sequencer: IDLE -> (DRIVE -> SETTLE -> CHECK) per pattern -> DONE.
    // busy drops and pass is updated on entry to DONE so both are already
    // valid while the done pulse is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode_q     <= 2'd0;
            idx        <= 9'd0;
            settle_cnt <= '0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'd0;
            first_fail <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        err_count  <= 16'd0;
                        first_fail <= 8'h00;
                        pass       <= 1'b0;
                        idx        <= 9'd0;
                        busy       <= 1'b1;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    tx_data    <= pattern_cur;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (err_count == 16'd0) begin
                            first_fail <= tx_data;
                        end
                    end
                    if (idx == last_idx) begin
                        busy  <= 1'b0;
                        pass  <= (err_next == 16'd0);
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 9'd1;
                        state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_loop_tester.sv
// Testbench for pmod_loop_tester: a configurable fault model sits in the
// loopback path, a table of directed runs plus randomised runs are checked
// against a pattern-level reference model, and hand-written sequences cover
// reset mid-run, restart attempts, start held high and settle glitches.

module tb_pmod_loop_tester;

    localparam int SETTLE    = 16;
    localparam int PER       = SETTLE + 2;
    localparam int RUN_LIMIT = 6000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [7:0]  first_fail;

    // Loopback fault configuration
    logic [7:0]  and_mask;
    logic [7:0]  or_mask;
    bit          short01;
    bit          glitch_en;
    logic [7:0]  glitch_xor;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] and_mask;
        logic [7:0] or_mask;
        bit         short01;
        int         exp_err;
        logic [7:0] exp_ff;
        bit         exp_pass;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [10];

    pmod_loop_tester #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .rx_data    (rx_data),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the faulty cable returns for a given driven byte.
    function automatic logic [7:0] loopback(input logic [7:0] p, input logic [7:0] am,
                                            input logic [7:0] om, input bit sh);
        logic [7:0] r;
        r = (p & am) | om;
        if (sh) r[1] = r[0];
        return r;
    endfunction

    always_comb begin
        rx_data = glitch_en ? (tx_data ^ glitch_xor) : loopback(tx_data, and_mask, or_mask, short01);
    end

    // Reference: the pattern list of each mode, straight from the mode rules.
    function automatic logic [7:0] ref_pattern(input logic [1:0] m, input int i);
        case (m)
            2'd0:    return 8'(1 << i);
            2'd1:    return ~8'(1 << i);
            2'd2:    return 8'(i);
            default: return (i == 0) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    function automatic int ref_count(input logic [1:0] m);
        case (m)
            2'd2:    return 256;
            2'd3:    return 2;
            default: return 8;
        endcase
    endfunction

    // Reference: walk every pattern through the fault and tally mismatches.
    task automatic ref_model(input logic [1:0] m, input logic [7:0] am, input logic [7:0] om,
                             input bit sh, output int n_err, output logic [7:0] ff, output int n);
        logic [7:0] p;
        n     = ref_count(m);
        n_err = 0;
        ff    = 8'h00;
        for (int i = 0; i < n; i++) begin
            p = ref_pattern(m, i);
            if (loopback(p, am, om, sh) != p) begin
                if (n_err == 0) ff = p;
                n_err++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Start one run and follow it to its done pulse. Optionally glitches rx
    // in SETTLE phases 1..glitch_last and re-pulses start (with a new mode)
    // at cycle restart_at. cyc is the cycle count from start acceptance.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] am, input logic [7:0] om,
                                 input bit sh, input int glitch_last, input int restart_at,
                                 input logic [1:0] new_mode, output int cyc, output bit seen);
        int ph;
        @(negedge clk);
        mode     = m;
        and_mask = am;
        or_mask  = om;
        short01  = sh;
        start    = 1'b1;
        cyc      = 0;
        seen     = 1'b0;
        while (!seen && cyc < RUN_LIMIT) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (restart_at > 0 && cyc == restart_at);
            if (restart_at > 0 && cyc == restart_at) mode = new_mode;
            if (glitch_last > 0) begin
                ph         = (cyc - 1) % PER;
                glitch_xor = 8'($urandom_range(1, 255));
                glitch_en  = (ph >= 1 && ph <= glitch_last);
            end
            if (done) seen = 1'b1;
        end
        glitch_en = 1'b0;
        start     = 1'b0;
        if (!seen) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int         cyc;
        bit         seen;
        int         n_err;
        int         n;
        int         extra;
        int         first_done;
        int         second_done;
        bit         pass_first;
        logic [7:0] ff;
        logic [1:0] rm;
        logic [7:0] ram;
        logic [7:0] rom;
        bit         rsh;

        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        and_mask   = 8'hFF;
        or_mask    = 8'h00;
        short01    = 1'b0;
        glitch_en  = 1'b0;
        glitch_xor = 8'h00;

        //                 mode   and    or     sh  err  ff     pass cycles
        vecs[0] = '{2'd0, 8'hFF, 8'h00, 1'b0, 0,   8'h00, 1'b1, 145};
        vecs[1] = '{2'd1, 8'hFF, 8'h00, 1'b0, 0,   8'h00, 1'b1, 145};
        vecs[2] = '{2'd2, 8'hFF, 8'h00, 1'b0, 0,   8'h00, 1'b1, 4609};
        vecs[3] = '{2'd3, 8'hFF, 8'h00, 1'b0, 0,   8'h00, 1'b1, 37};
        vecs[4] = '{2'd0, 8'hFB, 8'h00, 1'b0, 1,   8'h04, 1'b0, 145};
        vecs[5] = '{2'd1, 8'hFB, 8'h00, 1'b0, 7,   8'hFE, 1'b0, 145};
        vecs[6] = '{2'd2, 8'hFB, 8'h00, 1'b0, 128, 8'h04, 1'b0, 4609};
        vecs[7] = '{2'd3, 8'hFF, 8'h00, 1'b1, 2,   8'h55, 1'b0, 37};
        vecs[8] = '{2'd3, 8'hFF, 8'h80, 1'b0, 1,   8'h55, 1'b0, 37};
        vecs[9] = '{2'd1, 8'hFF, 8'h01, 1'b0, 1,   8'hFE, 1'b0, 145};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tx", tx_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_err", err_count, 0);
        checkOutput("reset_ff", first_fail, 0);
        reset = 1'b0;

        $display("[TB] directed table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].and_mask, vecs[v].or_mask, vecs[v].short01,
                          0, 0, 2'd0, cyc, seen);
            checkOutput($sformatf("vec%0d_latency", v), cyc, vecs[v].exp_cycles);
            checkOutput($sformatf("vec%0d_err", v), err_count, vecs[v].exp_err);
            checkOutput($sformatf("vec%0d_first_fail", v), first_fail, vecs[v].exp_ff);
            checkOutput($sformatf("vec%0d_pass", v), pass, vecs[v].exp_pass);
            checkOutput($sformatf("vec%0d_busy_at_done", v), busy, 0);
        end

        $display("[TB] settle glitches");
        // Wrong until two cycles before CHECK: flushed by the synchronizer.
        applyStimulus(2'd0, 8'hFF, 8'h00, 1'b0, PER - 4, 0, 2'd0, cyc, seen);
        checkOutput("glitch_early_err", err_count, 0);
        checkOutput("glitch_early_pass", pass, 1);
        // Wrong through two cycles before CHECK: reaches the compare.
        applyStimulus(2'd0, 8'hFF, 8'h00, 1'b0, PER - 3, 0, 2'd0, cyc, seen);
        checkOutput("glitch_late_err", err_count, 8);
        checkOutput("glitch_late_first_fail", first_fail, 8'h01);
        checkOutput("glitch_late_pass", pass, 0);

        $display("[TB] restart attempt and mode change mid-run");
        applyStimulus(2'd0, 8'hFB, 8'h00, 1'b0, 0, 30, 2'd2, cyc, seen);
        checkOutput("midrun_latency", cyc, 145);
        checkOutput("midrun_err", err_count, 1);
        checkOutput("midrun_first_fail", first_fail, 8'h04);
        extra = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) extra++;
        end
        checkOutput("midrun_no_second_run", extra, 0);

        $display("[TB] start held high");
        @(negedge clk);
        mode        = 2'd3;
        and_mask    = 8'hFF;
        or_mask     = 8'h00;
        short01     = 1'b0;
        start       = 1'b1;
        cyc         = 0;
        first_done  = 0;
        second_done = 0;
        pass_first  = 1'b0;
        while (second_done == 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (first_done != 0 && cyc == first_done + 1) checkOutput("held_idle_busy", busy, 0);
            if (first_done != 0 && cyc == first_done + 2) checkOutput("held_restart_busy", busy, 1);
            if (done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    pass_first = pass;
                end else begin
                    second_done = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("held_first_done", first_done, 37);
        checkOutput("held_first_pass", pass_first, 1);
        checkOutput("held_second_done", second_done, 75);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("held_released_busy", busy, 0);

        $display("[TB] reset mid-run");
        @(negedge clk);
        mode     = 2'd2;
        and_mask = 8'hFF;
        or_mask  = 8'h01;
        start    = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("prereset_tx", tx_data, 8'h02);
        checkOutput("prereset_err", err_count, 1);
        checkOutput("prereset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_tx", tx_data, 0);
        checkOutput("midreset_err", err_count, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_ff", first_fail, 0);
        applyStimulus(2'd2, 8'hFF, 8'h00, 1'b0, 0, 0, 2'd0, cyc, seen);
        checkOutput("postreset_latency", cyc, 4609);
        checkOutput("postreset_err", err_count, 0);
        checkOutput("postreset_pass", pass, 1);

        $display("[TB] randomised runs");
        for (int r = 0; r < 6; r++) begin
            rm  = 2'($urandom_range(0, 3));
            ram = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            rom = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            rsh = bit'($urandom_range(0, 1));
            ref_model(rm, ram, rom, rsh, n_err, ff, n);
            applyStimulus(rm, ram, rom, rsh, 0, 0, 2'd0, cyc, seen);
            checkOutput($sformatf("rand%0d_latency", r), cyc, n * PER + 1);
            checkOutput($sformatf("rand%0d_err", r), err_count, n_err);
            checkOutput($sformatf("rand%0d_first_fail", r), first_fail, ff);
            checkOutput($sformatf("rand%0d_pass", r), pass, (n_err == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_loop_tester.md
Name: pmod_loop_tester

Overview:
Active counterpart to the Basys3 pmod pass-through test setup. It drives a known sequence of 8-bit patterns onto a pmod output bank and samples the looped-back data on a pmod input bank. Each returned byte is compared with the byte sent, and the block reports pass/fail, the error count and the first failing pattern, for display on LEDs. It sits inside the board top, between the switch/button inputs, the JA/JB pmod pins and the LED bank.

Parameters:
SETTLE_CYCLES, 16, number of cycles between driving a pattern and comparing it; minimum 3, because of the 2-flop input synchronizer.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
start  input  1  level or pulse; starts a run when sampled high in IDLE.
mode  input  2  pattern set, sampled at start: 0 walking-one, 1 walking-zero, 2 binary count, 3 alternating 0x55/0xAA.
rx_data  input  8  asynchronous pmod input (loopback return).
tx_data  output  8  pmod output pattern.
busy  output  1  high from the cycle after start is accepted until DONE.
done  output  1  one-cycle pulse at the end of a run.
pass  output  1  1 if the last completed run had zero errors; held until the next start.
err_count  output  16  mismatches in the current or last run.
first_fail  output  8  tx pattern of the first mismatch in the run; 0x00 if none.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronizer flops 0.
- rx_data always passes through a 2-flop synchronizer to give rx_sync. It is never sampled raw.
- Pattern count N and pattern(i) by latched mode:
  - mode 0: N=8, pattern = 1<<i.
  - mode 1: N=8, pattern = ~(1<<i).
  - mode 2: N=256, pattern = i[7:0].
  - mode 3: N=2, i=0 gives 0x55, i=1 gives 0xAA.
- Pattern index i is 9 bits wide and starts at 0.
- IDLE:
  - When start=1: latch mode, clear err_count, first_fail, pass and i, set busy, then go to DRIVE.
  - start is ignored in every other state.
- DRIVE, 1 cycle: tx_data <= pattern(i); load settle counter to SETTLE_CYCLES-1; go to SETTLE.
- SETTLE, SETTLE_CYCLES cycles: count down; at 0 go to CHECK.
- CHECK, 1 cycle: compare rx_sync with tx_data.
  - On mismatch: err_count += 1; if err_count was 0, first_fail <= tx_data.
  - If i == N-1, go to DONE; otherwise i += 1 and go to DRIVE.
- DONE, 1 cycle:
  - done=1, busy<=0, pass <= (err_count==0).
  - tx_data keeps the last pattern.
  - Return to IDLE.
- Timing:
  - Cycles per pattern: SETTLE_CYCLES+2.
  - The done pulse appears N*(SETTLE_CYCLES+2)+1 cycles after the cycle start is accepted.
- err_count fits without saturation (max 256). The counter is still 16 bits wide and must not wrap within a run.
- Mismatches at the compare cycle (CHECK) are the only errors; rx changes during SETTLE are not errors.
- Reset mid-run: the next cycle is in IDLE with all outputs 0, and tx_data returns to 0x00 immediately.
- Start held high continuously: a new run begins on the cycle after DONE returns to IDLE. pass and done from the previous run remain observable for that one DONE cycle.
- mode changes during a run have no effect.

Test Plan:
1. Clean loopback: rx_data = tx_data, mode 0, SETTLE_CYCLES=16, pulse start.
   -> done at cycle 8*18+1 = 145 after start; pass=1, err_count=0, first_fail=0x00.
2. Stuck-low bit 2: rx_data = tx_data & 0xFB.
   -> mode 0: err_count=1, first_fail=0x04, pass=0.
   -> mode 1: err_count=7, first_fail=0xFE.
   -> mode 2: err_count=128, first_fail=0x04.
3. Shorted bits 0/1: rx = tx with bit1 forced equal to bit0, mode 3.
   -> 0x55 returns 0x57 and 0xAA returns 0xA8; err_count=2, first_fail=0x55.
4. Reset at cycle 50 of a mode-2 run.
   -> the next cycle has busy=0, tx_data=0x00, err_count=0.
   -> a new start then completes 256 patterns normally.
5. start pulsed again while busy, and mode changed mid-run.
   -> no restart; N and patterns follow the originally latched mode; exactly one done pulse.
6. rx glitch: rx toggles during SETTLE but is correct by SETTLE cycle 3.
   -> err_count=0; also check that an rx error held only through CHECK-1 and cleared 2 cycles before CHECK is not counted (synchronizer latency 2).
